pipe_ex: RTL and testbench

Execute stage of the five-stage in-order pipeline; sits between the decode stage and pipe_MEM. It latches decoded operands through the valid/allowin handshake and computes the ALU result. It runs DIV/MOD instructions on an iterative 32-cycle restoring divider, stalling the pipe meanwhile. It issues the data-SRAM request so read data arrives exactly when the instruction is held in MEM.

---
 rtl/pipe_ex_pkg.sv | 54 +++++
 rtl/pipe_ex_if.sv | 51 +++++
 rtl/pipe_ex_div_iter.sv | 82 ++++++++
 rtl/pipe_ex.sv | 140 ++++++++++++++
 tb/tb_pipe_ex.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ex_pkg.sv
// pipe_ex shared definitions.
// Op bit positions, store sizes, divider states and the ID->EX payload.
package pipe_ex_pkg;

    localparam int ALU_W    = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam int DIV_W  = 0;
    localparam int MOD_W  = 1;
    localparam int DIV_WU = 2;
    localparam int MOD_WU = 3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    typedef struct packed {
        logic [31:0]      pc;
        logic [ALU_W-1:0] alu_op;
        logic [31:0]      src1;
        logic [31:0]      src2;
        logic [3:0]       div_op;
        logic             rf_we;
        logic [4:0]       rf_waddr;
        logic             res_from_mem;
        logic             mem_we;
        logic [1:0]       mem_size;
        logic [31:0]      rkd;
    } id_ex_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/pipe_ex_if.sv
// pipe_ex bus: ID->EX handoff inputs, EX->MEM outputs and data SRAM request.
// master = surrounding pipeline, slave = execute stage.
interface pipe_ex_if;

    logic        from_valid;
    logic        from_allowin;
    logic [31:0] from_pc;
    logic [11:0] alu_op_ID;
    logic [31:0] alu_src1_ID;
    logic [31:0] alu_src2_ID;
    logic [3:0]  div_op_ID;
    logic        rf_we_ID;
    logic [4:0]  rf_waddr_ID;
    logic        res_from_mem_ID;
    logic        mem_we_ID;
    logic [1:0]  mem_size_ID;
    logic [31:0] rkd_value_ID;

    logic        to_allowin;
    logic        to_valid;
    logic [31:0] PC;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        res_from_mem;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport master (
        output from_valid, from_allowin, from_pc, alu_op_ID,
        output alu_src1_ID, alu_src2_ID, div_op_ID, rf_we_ID,
        output rf_waddr_ID, res_from_mem_ID, mem_we_ID,
        output mem_size_ID, rkd_value_ID,
        input  to_allowin, to_valid, PC, alu_result, rf_we,
        input  rf_waddr, res_from_mem, data_sram_en,
        input  data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  from_valid, from_allowin, from_pc, alu_op_ID,
        input  alu_src1_ID, alu_src2_ID, div_op_ID, rf_we_ID,
        input  rf_waddr_ID, res_from_mem_ID, mem_we_ID,
        input  mem_size_ID, rkd_value_ID,
        output to_allowin, to_valid, PC, alu_result, rf_we,
        output rf_waddr, res_from_mem, data_sram_en,
        output data_sram_we, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/pipe_ex_div_iter.sv
// div_iter: 32-step restoring divider, one quotient bit per cycle.
// start is held by the stage; dropping it in DONE releases the result.
module div_iter
    import pipe_ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic [32:0] r_sh;
    logic [33:0] diff;
    logic        ge;

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        r_sh  = {rem_q, quo_q[31]};
        diff  = {1'b0, r_sh} - {2'b00, dvs_q};
        ge    = ~diff[33];
        rem_d = ge ? diff[31:0] : r_sh[31:0];
        quo_d = {quo_q[30:0], ge};
    end

    // Divider FSM and magnitude datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_q <= DIV_BUSY;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= signed_op ? abs32(dividend) : dividend;
                        dvs_q   <= signed_op ? abs32(divisor) : divisor;
                        neg_q_q <= signed_op & (dividend[31] ^ divisor[31]);
                        neg_r_q <= signed_op & dividend[31];
                    end
                end
                DIV_BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!start) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign done      = (state_q == DIV_DONE);
    assign quotient  = neg_q_q ? -quo_q : quo_q;
    assign remainder = neg_r_q ? -rem_q : rem_q;

endmodule

// File: rtl/pipe_ex.sv
// pipe_ex: execute stage between decode and memory.
// Latches the ID bundle, computes ALU/divide result, issues the data SRAM request.
module pipe_ex
    import pipe_ex_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    pipe_ex_if.slave bus
);

    logic        valid_q;
    id_ex_t      pay_q, pay_d;
    logic        is_div;
    logic        div_done;
    logic        ready_go;
    logic        allowin;
    logic        handoff;
    logic        div_start;
    logic        signed_op;
    logic        sel_quo;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] alu_out;
    logic [31:0] result;
    logic [3:0]  we_raw;
    logic [31:0] wdata;

    // Pack the incoming ID bundle
    always_comb begin
        pay_d              = '0;
        pay_d.pc           = bus.from_pc;
        pay_d.alu_op       = bus.alu_op_ID;
        pay_d.src1         = bus.alu_src1_ID;
        pay_d.src2         = bus.alu_src2_ID;
        pay_d.div_op       = bus.div_op_ID;
        pay_d.rf_we        = bus.rf_we_ID;
        pay_d.rf_waddr     = bus.rf_waddr_ID;
        pay_d.res_from_mem = bus.res_from_mem_ID;
        pay_d.mem_we       = bus.mem_we_ID;
        pay_d.mem_size     = bus.mem_size_ID;
        pay_d.rkd          = bus.rkd_value_ID;
    end

    assign is_div   = |pay_q.div_op;
    assign ready_go = !is_div || div_done;
    assign allowin  = !valid_q || (ready_go && bus.from_allowin);
    assign handoff  = valid_q && ready_go && bus.from_allowin;

    // Start stays high until the result is handed to MEM
    assign div_start = valid_q && is_div && !(div_done && bus.from_allowin);
    assign signed_op = pay_q.div_op[DIV_W] | pay_q.div_op[MOD_W];
    assign sel_quo   = pay_q.div_op[DIV_W] | pay_q.div_op[DIV_WU];

    // Stage valid and payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else if (allowin) begin
            valid_q <= bus.from_valid;
            if (bus.from_valid) begin
                pay_q <= pay_d;
            end
        end
    end

    div_iter u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .signed_op (signed_op),
        .dividend  (pay_q.src1),
        .divisor   (pay_q.src2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // One-hot ALU on the latched operands
    always_comb begin
        alu_out = '0;
        unique case (1'b1)
            pay_q.alu_op[ALU_ADD]:  alu_out = pay_q.src1 + pay_q.src2;
            pay_q.alu_op[ALU_SUB]:  alu_out = pay_q.src1 - pay_q.src2;
            pay_q.alu_op[ALU_SLT]:
                alu_out = {31'd0, $signed(pay_q.src1) < $signed(pay_q.src2)};
            pay_q.alu_op[ALU_SLTU]:
                alu_out = {31'd0, pay_q.src1 < pay_q.src2};
            pay_q.alu_op[ALU_AND]:  alu_out = pay_q.src1 & pay_q.src2;
            pay_q.alu_op[ALU_NOR]:  alu_out = ~(pay_q.src1 | pay_q.src2);
            pay_q.alu_op[ALU_OR]:   alu_out = pay_q.src1 | pay_q.src2;
            pay_q.alu_op[ALU_XOR]:  alu_out = pay_q.src1 ^ pay_q.src2;
            pay_q.alu_op[ALU_SLL]:  alu_out = pay_q.src1 << pay_q.src2[4:0];
            pay_q.alu_op[ALU_SRL]:  alu_out = pay_q.src1 >> pay_q.src2[4:0];
            pay_q.alu_op[ALU_SRA]:
                alu_out = $signed(pay_q.src1) >>> pay_q.src2[4:0];
            pay_q.alu_op[ALU_LUI]:  alu_out = pay_q.src2;
            default:                alu_out = '0;
        endcase
    end

    assign result = is_div ? (sel_quo ? div_quo : div_rem) : alu_out;

    // Store byte lanes and lane-replicated write data
    always_comb begin
        we_raw = 4'hF;
        wdata  = pay_q.rkd;
        case (pay_q.mem_size)
            SZ_BYTE: begin
                we_raw = 4'b0001 << result[1:0];
                wdata  = {4{pay_q.rkd[7:0]}};
            end
            SZ_HALF: begin
                we_raw = 4'b0011 << {result[1], 1'b0};
                wdata  = {2{pay_q.rkd[15:0]}};
            end
            SZ_WORD: begin
                we_raw = 4'hF;
                wdata  = pay_q.rkd;
            end
            default: begin
                we_raw = 4'hF;
                wdata  = pay_q.rkd;
            end
        endcase
    end

    assign bus.to_allowin      = allowin;
    assign bus.to_valid        = valid_q && ready_go;
    assign bus.PC              = pay_q.pc;
    assign bus.alu_result      = result;
    assign bus.rf_we           = pay_q.rf_we;
    assign bus.rf_waddr        = pay_q.rf_waddr;
    assign bus.res_from_mem    = pay_q.res_from_mem;
    assign bus.data_sram_en    = handoff && (pay_q.res_from_mem || pay_q.mem_we);
    assign bus.data_sram_we    = pay_q.mem_we ? we_raw : 4'h0;
    assign bus.data_sram_addr  = result;
    assign bus.data_sram_wdata = wdata;

endmodule

// File: tb/tb_pipe_ex.sv
// tb_pipe_ex: vector table through a scoreboard, plus divide latency,
// MEM stall and reset-while-busy sequences.
module tb_pipe_ex;
    import pipe_ex_pkg::*;

    typedef struct {
        logic [11:0] op;
        logic [3:0]  dv;
        logic [31:0] a;
        logic [31:0] b;
        logic        st;
        logic        ld;
        logic [1:0]  sz;
        logic [31:0] rkd;
        logic [31:0] res;
        logic        en;
        logic [3:0]  we;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic        ld;
        logic [31:0] res;
        logic        en;
        logic [3:0]  we;
        logic [31:0] wd;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    pipe_ex_if bus();

    pipe_ex dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] op(input int i);
        return 12'd1 << i;
    endfunction

    function automatic vec_t mk(
        input logic [11:0] o, input logic [3:0] d,
        input logic [31:0] a, input logic [31:0] b,
        input logic st, input logic ld, input logic [1:0] sz,
        input logic [31:0] rkd, input logic [31:0] res,
        input logic en, input logic [3:0] we, input logic [31:0] wd);
        vec_t v;
        v.op = o;  v.dv = d;  v.a = a;  v.b = b;
        v.st = st; v.ld = ld; v.sz = sz; v.rkd = rkd;
        v.res = res; v.en = en; v.we = we; v.wd = wd;
        return v;
    endfunction

    function automatic vec_t alu(input int i, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] r);
        return mk(op(i), 4'd0, a, b, 1'b0, 1'b0, SZ_WORD, 32'd0,
                  r, 1'b0, 4'h0, 32'd0);
    endfunction

    function automatic vec_t dv(input logic [3:0] d, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] r);
        return mk(12'd0, d, a, b, 1'b0, 1'b0, SZ_WORD, 32'd0,
                  r, 1'b0, 4'h0, 32'd0);
    endfunction

    // Scoreboard: every EX->MEM handoff must match the oldest accepted entry
    always @(negedge clk) begin
        if (!reset && bus.to_valid && bus.from_allowin) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handoff got_pc=%h want=none", bus.PC);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pc", bus.PC, e.pc);
                chk("result", bus.alu_result, e.res);
                chk("sram_addr", bus.data_sram_addr, e.res);
                chk("sram_en", {31'd0, bus.data_sram_en}, {31'd0, e.en});
                chk("sram_we", {28'd0, bus.data_sram_we}, {28'd0, e.we});
                chk("sram_wdata", bus.data_sram_wdata, e.wd);
                chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, e.waddr});
                chk("rf_we", {31'd0, bus.rf_we}, 32'd1);
                chk("res_from_mem", {31'd0, bus.res_from_mem}, {31'd0, e.ld});
            end
        end
    end

    // Offer one instruction; record its expectation when EX accepts it
    task automatic issue(input vec_t v, input logic [31:0] pc);
        int   g;
        exp_t e;
        g = 0;
        bus.from_pc         = pc;
        bus.alu_op_ID       = v.op;
        bus.alu_src1_ID     = v.a;
        bus.alu_src2_ID     = v.b;
        bus.div_op_ID       = v.dv;
        bus.rf_we_ID        = 1'b1;
        bus.rf_waddr_ID     = pc[6:2];
        bus.res_from_mem_ID = v.ld;
        bus.mem_we_ID       = v.st;
        bus.mem_size_ID     = v.sz;
        bus.rkd_value_ID    = v.rkd;
        bus.from_valid      = 1'b1;
        @(negedge clk);
        while (!bus.to_allowin && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!bus.to_allowin) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout pc=%h got=blocked want=accepted", pc);
        end else begin
            e.pc = pc; e.waddr = pc[6:2]; e.ld = v.ld;
            e.res = v.res; e.en = v.en; e.we = v.we; e.wd = v.wd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.from_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    // Divide from an empty stage: to_valid must rise 33 cycles after latch
    task automatic div_run(input vec_t v, input logic [31:0] pc);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        issue(v, pc);
        @(negedge clk);
        while (!bus.to_valid && n < 100) begin
            if (bus.to_allowin) bad++;
            @(negedge clk);
            n++;
        end
        chk("div_latency", n, 33);
        chk("div_busy_allowin", bad, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        reset               = 1'b1;
        bus.from_valid      = 1'b0;
        bus.from_allowin    = 1'b1;
        bus.from_pc         = '0;
        bus.alu_op_ID       = '0;
        bus.alu_src1_ID     = '0;
        bus.alu_src2_ID     = '0;
        bus.div_op_ID       = '0;
        bus.rf_we_ID        = 1'b0;
        bus.rf_waddr_ID     = '0;
        bus.res_from_mem_ID = 1'b0;
        bus.mem_we_ID       = 1'b0;
        bus.mem_size_ID     = '0;
        bus.rkd_value_ID    = '0;

        tbl.push_back(alu(ALU_ADD, 32'd5, 32'd7, 32'd12));
        tbl.push_back(alu(ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE));
        tbl.push_back(alu(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1));
        tbl.push_back(alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0));
        tbl.push_back(alu(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234));
        tbl.push_back(alu(ALU_NOR, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF));
        tbl.push_back(alu(ALU_OR, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034));
        tbl.push_back(alu(ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F));
        tbl.push_back(alu(ALU_SLL, 32'd1, 32'h24, 32'h10));
        tbl.push_back(alu(ALU_SRL, 32'h8000_0000, 32'd31, 32'd1));
        tbl.push_back(alu(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000));
        tbl.push_back(alu(ALU_LUI, 32'h1234, 32'hABCD_0000, 32'hABCD_0000));
        tbl.push_back(mk(op(ALU_ADD), 4'd0, 32'h1000, 32'd3, 1'b1, 1'b0,
                         SZ_BYTE, 32'hAB, 32'h1003, 1'b1, 4'h8, 32'hABAB_ABAB));
        tbl.push_back(mk(op(ALU_ADD), 4'd0, 32'h1000, 32'd0, 1'b1, 1'b0,
                         SZ_BYTE, 32'h12, 32'h1000, 1'b1, 4'h1, 32'h1212_1212));
        tbl.push_back(mk(op(ALU_ADD), 4'd0, 32'h2000, 32'd2, 1'b1, 1'b0,
                         SZ_HALF, 32'h1234_CDEF, 32'h2002, 1'b1, 4'hC, 32'hCDEF_CDEF));
        tbl.push_back(mk(op(ALU_ADD), 4'd0, 32'h2000, 32'd0, 1'b1, 1'b0,
                         SZ_HALF, 32'h0000_5678, 32'h2000, 1'b1, 4'h3, 32'h5678_5678));
        tbl.push_back(mk(op(ALU_ADD), 4'd0, 32'h3000, 32'd0, 1'b1, 1'b0,
                         SZ_WORD, 32'hDEAD_BEEF, 32'h3000, 1'b1, 4'hF, 32'hDEAD_BEEF));
        tbl.push_back(mk(op(ALU_ADD), 4'd0, 32'h4000, 32'd4, 1'b0, 1'b1,
                         SZ_WORD, 32'd0, 32'h4004, 1'b1, 4'h0, 32'd0));
        tbl.push_back(dv(4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD));
        tbl.push_back(dv(4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF));
        tbl.push_back(dv(4'b0100, 32'd10, 32'd0, 32'hFFFF_FFFF));
        tbl.push_back(dv(4'b1000, 32'd10, 32'd0, 32'd10));
        tbl.push_back(dv(4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
        tbl.push_back(dv(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0));
        tbl.push_back(dv(4'b0001, 32'hFFFF_FFF9, 32'd0, 32'd1));
        tbl.push_back(dv(4'b0010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9));
        tbl.push_back(dv(4'b0100, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF));
        tbl.push_back(dv(4'b1000, 32'd100, 32'd7, 32'd2));
        tbl.push_back(alu(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0));

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_to_valid", {31'd0, bus.to_valid}, 32'd0);
        chk("rst_to_allowin", {31'd0, bus.to_allowin}, 32'd1);
        chk("rst_sram_en", {31'd0, bus.data_sram_en}, 32'd0);
        chk("rst_sram_we", {28'd0, bus.data_sram_we}, 32'd0);
        chk("rst_pc", bus.PC, 32'd0);
        chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("rst_res_from_mem", {31'd0, bus.res_from_mem}, 32'd0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) issue(tbl[i], 32'h1C00_0000 + 32'(i) * 32'd4);
        drain();

        div_run(dv(4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD), 32'h1C00_1000);
        div_run(dv(4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF), 32'h1C00_1004);

        // Load held by a MEM stall: no request until release, then one pulse
        bus.from_allowin = 1'b0;
        issue(mk(op(ALU_ADD), 4'd0, 32'h4000, 32'd8, 1'b0, 1'b1, SZ_WORD,
                 32'd0, 32'h4008, 1'b1, 4'h0, 32'd0), 32'h1C00_2000);
        bus.from_pc     = 32'hDEAD_0000;
        bus.alu_src1_ID = 32'h5555_5555;
        repeat (3) begin
            @(negedge clk);
            chk("stall_en", {31'd0, bus.data_sram_en}, 32'd0);
            chk("stall_valid", {31'd0, bus.to_valid}, 32'd1);
            chk("stall_allowin", {31'd0, bus.to_allowin}, 32'd0);
            chk("stall_result", bus.alu_result, 32'h4008);
            chk("stall_pc", bus.PC, 32'h1C00_2000);
            @(posedge clk);
            #1;
        end
        bus.from_allowin = 1'b1;
        @(negedge clk);
        chk("release_en", {31'd0, bus.data_sram_en}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_en", {31'd0, bus.data_sram_en}, 32'd0);
        chk("after_valid", {31'd0, bus.to_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Divide finishing into a MEM stall: DONE and result persist
        bus.from_allowin = 1'b0;
        issue(dv(4'b1000, 32'd100, 32'd7, 32'd2), 32'h1C00_3000);
        g = 0;
        @(negedge clk);
        while (!bus.to_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("dstall_done", {31'd0, bus.to_valid}, 32'd1);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("dstall_valid", {31'd0, bus.to_valid}, 32'd1);
            chk("dstall_result", bus.alu_result, 32'd2);
        end
        @(posedge clk);
        #1;
        bus.from_allowin = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("dstall_gone", {31'd0, bus.to_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Reset in BUSY cycle 10 drops the divide
        bus.alu_op_ID   = 12'd0;
        bus.div_op_ID   = 4'b0001;
        bus.alu_src1_ID = 32'd100;
        bus.alu_src2_ID = 32'd3;
        bus.from_valid  = 1'b1;
        @(negedge clk);
        chk("rb_accept", {31'd0, bus.to_allowin}, 32'd1);
        @(posedge clk);
        #1;
        bus.from_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rb_busy_allowin", {31'd0, bus.to_allowin}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rb_valid", {31'd0, bus.to_valid}, 32'd0);
        chk("rb_allowin", {31'd0, bus.to_allowin}, 32'd1);
        @(posedge clk);
        #1;
        div_run(dv(4'b0001, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2), 32'h1C00_4000);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
